// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes (and, with RESET_SEQUENCER_DEBOUNCE_EN, debounces) reset sources and sequences p1v_resn
module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int HOLD_CYCLES     = 160000
) (
  input  logic       clock_160,
  input  logic       reset,
  input  logic       key_n,
  input  logic       plug_resn,
  input  logic       pll_locked,
  output logic       p1v_resn,
  output logic [1:0] state,
  output logic [7:0] reset_count
);
  localparam logic [1:0] ST_ASSERT    = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_key_sync, r_plug_sync, r_lock_sync;
  logic [1:0] w_sync, w_filt;
  logic w_lock, w_kp_req, w_req;
  logic [1:0] r_state, w_next;
  logic [HW-1:0] r_hold, w_hold_next;
  // Shift each raw input through its own synchronizer chain
  always_ff @(posedge clock_160) begin
    if (reset) begin
      r_key_sync  <= '0;
      r_plug_sync <= '0;
      r_lock_sync <= '0;
    end else begin
      r_key_sync  <= {r_key_sync[SYNC_STAGES-2:0], key_n};
      r_plug_sync <= {r_plug_sync[SYNC_STAGES-2:0], plug_resn};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end
  assign w_sync = {r_plug_sync[SYNC_STAGES-1], r_key_sync[SYNC_STAGES-1]};
  assign w_lock = r_lock_sync[SYNC_STAGES-1];
`ifdef RESET_SEQUENCER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] r_db_lvl;
  logic [DW-1:0] r_db_cnt [2];
  // Flip a level only after DEBOUNCE_CYCLES consecutive differing samples; a matching sample restarts the count
  always_ff @(posedge clock_160) begin
    if (reset) begin
      r_db_lvl <= '0;
      r_db_cnt <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_db_lvl[i]) r_db_cnt[i] <= '0;
        else if (r_db_cnt[i] == DB_MAX) begin
          r_db_lvl[i] <= w_sync[i];
          r_db_cnt[i] <= '0;
        end else r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
      end
    end
  end
  assign w_filt = r_db_lvl;
`else
  assign w_filt = w_sync;
`endif
  assign w_kp_req = ~&w_filt;
  assign w_req    = w_kp_req | ~w_lock;
  // Next-state decode; a request always wins over hold completion
  always_comb begin
    w_next      = r_state;
    w_hold_next = r_hold;
    case (r_state)
      ST_ASSERT:    if (!w_kp_req) w_next = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (w_kp_req) w_next = ST_ASSERT;
        else if (w_lock) begin
          w_next      = ST_HOLD;
          w_hold_next = '0;
        end
      end
      ST_HOLD: begin
        if (w_req) begin
          w_next      = ST_ASSERT;
          w_hold_next = '0;
        end else if (r_hold == HOLD_MAX) w_next = ST_RUN;
        else w_hold_next = r_hold + 1'b1;
      end
      default:      if (w_req) w_next = ST_ASSERT;
    endcase
  end
  // State, hold counter, registered reset output and saturating RUN-exit count
  always_ff @(posedge clock_160) begin
    if (reset) begin
      r_state     <= ST_ASSERT;
      r_hold      <= '0;
      p1v_resn    <= 1'b0;
      reset_count <= '0;
    end else begin
      r_state  <= w_next;
      r_hold   <= w_hold_next;
      p1v_resn <= (w_next == ST_RUN);
      if (r_state == ST_RUN && w_next == ST_ASSERT && reset_count != 8'hFF) reset_count <= reset_count + 1'b1;
    end
  end
  assign state = r_state;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized and directed checks of reset_sequencer against a behavioural model
module tb_reset_sequencer;
  localparam int S = 2, D = 4, H = 8;
`ifdef RESET_SEQUENCER_DEBOUNCE_EN
  localparam bit DB = 1'b1;
  localparam int DD = D;
`else
  localparam bit DB = 1'b0;
  localparam int DD = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, key_n = 1'b1, plug_resn = 1'b1, pll_locked = 1'b1;
  logic p1v_resn;
  logic [1:0] state;
  logic [7:0] reset_count;
  int n_chk = 0, n_pass = 0;
  bit kq[$], pq[$], lq[$], kh[$], ph[$];
  bit kf, pf;
  logic [1:0] m_st;
  logic m_p1v;
  logic [7:0] m_cnt;
  int m_h;

  always #5 clk = ~clk;

  reset_sequencer #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clock_160(clk), .reset(reset), .key_n(key_n), .plug_resn(plug_resn), .pll_locked(pll_locked),
    .p1v_resn(p1v_resn), .state(state), .reset_count(reset_count)
  );

  function automatic bit all_diff(input bit q[$], input bit v);
    if (q.size() < D) return 1'b0;
    foreach (q[i]) if (q[i] == v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step;
    bit ks, ps, ls, kf_use, pf_use, rkp, rq;
    if (reset) begin
      kq = {}; pq = {}; lq = {}; kh = {}; ph = {};
      repeat (S) begin kq.push_back(1'b0); pq.push_back(1'b0); lq.push_back(1'b0); end
      kf = 1'b0; pf = 1'b0; m_st = 2'd0; m_p1v = 1'b0; m_cnt = 8'd0; m_h = 0;
      return;
    end
    ks = kq[0]; ps = pq[0]; ls = lq[0];
    kf_use = DB ? kf : ks;
    pf_use = DB ? pf : ps;
    rkp = !(kf_use && pf_use);
    rq = rkp || !ls;
    case (m_st)
      2'd0: if (!rkp) m_st = 2'd1;
      2'd1: if (rkp) m_st = 2'd0; else if (ls) begin m_st = 2'd2; m_h = 0; end
      2'd2: if (rq) begin m_st = 2'd0; m_h = 0; end else if (m_h == H - 1) m_st = 2'd3; else m_h++;
      default: if (rq) begin m_st = 2'd0; if (m_cnt < 8'd255) m_cnt++; end
    endcase
    m_p1v = (m_st == 2'd3);
    kq.push_back(key_n); void'(kq.pop_front());
    pq.push_back(plug_resn); void'(pq.pop_front());
    lq.push_back(pll_locked); void'(lq.pop_front());
    kh.push_back(ks); if (kh.size() > D) void'(kh.pop_front());
    ph.push_back(ps); if (ph.size() > D) void'(ph.pop_front());
    if (all_diff(kh, kf)) begin kf = ks; kh = {}; end
    if (all_diff(ph, pf)) begin pf = ps; ph = {}; end
  endtask

  task automatic tick;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_n = 1'($urandom); plug_resn = 1'($urandom); pll_locked = 1'($urandom);
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL reset_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    n_chk++; if ({state, p1v_resn, reset_count} !== 11'd0) $display("FAIL reset_state: got %0d/%b/%0d exp 0/0/0", state, p1v_resn, reset_count); else n_pass++;
  endtask

  task automatic test_powerup;
    int w = -1, r = -1;
    logic [1:0] prev = 2'd0;
    bit ord_ok = 1'b1;
    key_n = 1'b1; plug_resn = 1'b1; pll_locked = 1'b1; reset = 1'b0;
    for (int i = 0; i < 60 && r < 0; i++) begin
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL powerup_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
      if (state !== prev && int'(state) != int'(prev) + 1) ord_ok = 1'b0;
      prev = state;
      if (state === 2'd1 && w < 0) w = i;
      if (p1v_resn === 1'b1 && r < 0) r = i;
    end
    n_chk++; if (!ord_ok || state !== 2'd3) $display("FAIL powerup_order: ordered=%b final=%0d exp ordered=1 final=3", ord_ok, state); else n_pass++;
    n_chk++; if (w < 0 || r < 0 || r - w != H + 1) $display("FAIL powerup_rise: got %0d cycles exp %0d", r - w, H + 1); else n_pass++;
    n_chk++; if (reset_count !== 8'd0) $display("FAIL powerup_count: got %0d exp 0", reset_count); else n_pass++;
  endtask

  task automatic test_bounce;
    int lat = -1;
`ifdef RESET_SEQUENCER_DEBOUNCE_EN
    int wdt = $urandom_range(D - 1, 1);
    key_n = 1'b0;
    repeat (wdt) tick();
    key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_chk++; if (p1v_resn !== 1'b1 || state !== 2'd3 || {state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL bounce_glitch: got %0d/%b/%0d exp 3/1/%0d", state, p1v_resn, reset_count, m_cnt); else n_pass++;
    end
`endif
    key_n = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      if (i > (DB ? D + 2 : 1)) key_n = 1'b1;
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL bounce_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
      if (state === 2'd0) lat = i;
    end
    key_n = 1'b1;
    n_chk++; if (lat != S + DD + 1) $display("FAIL bounce_latency: got %0d exp %0d", lat, S + DD + 1); else n_pass++;
    n_chk++; if (reset_count !== 8'd1) $display("FAIL bounce_count: got %0d exp 1", reset_count); else n_pass++;
    for (int i = 0; i < 80 && state !== 2'd3; i++) begin
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL bounce_recover: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    n_chk++; if (state !== 2'd3) $display("FAIL bounce_timeout: got state %0d exp 3", state); else n_pass++;
  endtask

  task automatic test_lock_loss;
    bit saw_run = 1'b0;
    int hc = 0;
    pll_locked = 1'b0;
    for (int i = 0; i < 20 && state !== 2'd1; i++) begin
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL lock_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    repeat ($urandom_range(3, 0)) tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 20 && state !== 2'd2; i++) begin
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL lock_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    repeat (3) tick();
    pll_locked = 1'b0;
    for (int i = 0; i < 10 && state !== 2'd0; i++) begin
      tick();
      if (state === 2'd3) saw_run = 1'b1;
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL lock_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    n_chk++; if (saw_run || state !== 2'd0) $display("FAIL lock_abort: got state %0d run_seen=%b exp state 0 run_seen=0", state, saw_run); else n_pass++;
    for (int i = 0; i < 10 && state !== 2'd1; i++) tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 10 && state !== 2'd2; i++) tick();
    for (int i = 0; i < 40 && state !== 2'd3; i++) begin
      if (state === 2'd2) hc++;
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL lock_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    n_chk++; if (hc != H || state !== 2'd3) $display("FAIL lock_rehold: got %0d hold cycles state %0d exp %0d state 3", hc, state, H); else n_pass++;
  endtask

  task automatic test_simultaneous;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int i = 0; i < 20 && state !== 2'd2; i++) begin
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL simul_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    repeat (H - 1 - S - DD) tick();
    plug_resn = 1'b0;
    repeat (S + DD) tick();
    n_chk++; if (state !== 2'd2) $display("FAIL simul_last_hold: got state %0d exp 2", state); else n_pass++;
    tick();
    n_chk++; if (state !== 2'd0 || p1v_resn !== 1'b0 || state !== m_st) $display("FAIL simul_priority: got %0d/%b exp 0/0", state, p1v_resn); else n_pass++;
    plug_resn = 1'b1;
    for (int i = 0; i < 60 && state !== 2'd3; i++) tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15, 0) == 0) key_n = ~key_n;
      if ($urandom_range(15, 0) == 0) plug_resn = ~plug_resn;
      if ($urandom_range(31, 0) == 0) pll_locked = ~pll_locked;
      tick();
      n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL random_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
    end
    key_n = 1'b1; plug_resn = 1'b1; pll_locked = 1'b1;
    for (int i = 0; i < 60 && state !== 2'd3; i++) tick();
  endtask

  task automatic test_saturation;
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i < 60 && state !== 2'd3; i++) begin
        tick();
        n_chk++; if ({state, p1v_resn, reset_count} !== {m_st, m_p1v, m_cnt}) $display("FAIL sat_model: got %0d/%b/%0d exp %0d/%b/%0d", state, p1v_resn, reset_count, m_st, m_p1v, m_cnt); else n_pass++;
      end
      if (state !== 2'd3) begin
        n_chk++;
        $display("FAIL sat_timeout: got state %0d exp 3 at round %0d", state, n);
        break;
      end
      pll_locked = 1'b0;
      repeat ($urandom_range(2, 1)) tick();
      pll_locked = 1'b1;
      for (int i = 0; i < 10 && state !== 2'd0; i++) tick();
    end
    for (int i = 0; i < 60 && state !== 2'd3; i++) tick();
    n_chk++; if (reset_count !== 8'd255 || reset_count !== m_cnt) $display("FAIL sat_count: got %0d exp 255", reset_count); else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++; if ({state, p1v_resn, reset_count} !== 11'd0) $display("FAIL sat_reset: got %0d/%b/%0d exp 0/0/0", state, p1v_resn, reset_count); else n_pass++;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_bounce();
    test_lock_loss();
    test_simultaneous();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
